uart_link: RTL

Byte-serial console port between the CPU's IO opcode decode (device 0 = RX, device 1 = TX) and the board RxD/TxD pins. It receives 8N1 frames into a 4-entry FIFO and transmits one 8N1 frame at a time from a single holding register. It exposes the same char-ready / TX-empty handshake the CPU skip tester already consumes. It adds framing-error and overrun flags, plus a buffered receive path, so characters are not lost while the CPU is busy.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_link.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the console UART slice:
//   - rx_state_t / tx_state_t : FSM state encodings for receiver and transmitter
//   - DATA_BITS               : character width (8N1 framing)
//   - baud_div()              : clock cycles per bit, CLK_HZ / BAUD
//   - baud_cnt_width()        : width of a counter that spans 0 .. DIV-1
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int DATA_BITS = 8;

    // Whole clock cycles per bit period; any remainder is simply dropped.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Enough bits to count up to DIV-1, never narrower than one bit.
    function automatic int baud_cnt_width(input int clk_hz, input int baud);
        int div;
        div = clk_hz / baud;
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO buffering received characters until the CPU pops them.
// Ports:
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   push, push_data     : write strobe and byte (ignored when full, unless a
//                         pop in the same cycle frees the slot)
//   pop                 : remove head (ignored when empty)
//   head                : combinational view of the oldest entry
//   full, empty         : occupancy status
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic                 full,
    output logic                 empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W:0]       count;
    logic                 do_push;
    logic                 do_pop;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage is cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_link.sv
// ---------------------------------------------------------------------------
// uart_link
// 8N1 console port: buffered receiver with 4-deep FIFO, single-register
// transmitter, and sticky framing-error / overrun flags.
// Ports:
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   RxD                 : asynchronous serial input, idles high
//   readRX              : pop strobe for the received-character FIFO
//   charReady, RXchar   : FIFO non-empty and FIFO head byte
//   writeTX, TXchar     : load strobe and byte for the transmitter
//   TXempty             : transmitter idle, writeTX will be accepted
//   TxD                 : registered serial output, idles high
//   rxOverrun           : sticky, good frame arrived with FIFO full
//   rxFrameErr          : sticky, stop bit sampled low
// ---------------------------------------------------------------------------
module uart_link
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 RxD,
    input  logic                 readRX,
    output logic                 charReady,
    output logic [DATA_BITS-1:0] RXchar,
    input  logic                 writeTX,
    input  logic [DATA_BITS-1:0] TXchar,
    output logic                 TXempty,
    output logic                 TxD,
    output logic                 rxOverrun,
    output logic                 rxFrameErr
);

    localparam int              DIV       = baud_div(CLK_HZ, BAUD);
    localparam int              CNT_W     = baud_cnt_width(CLK_HZ, BAUD);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    logic                 rx_meta;
    logic                 rxs;
    rx_state_t            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_stop_now;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;

    // Two-flop synchronizer; resets high so an idle line never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    // The push decision is made on the stop-sample edge itself so the byte is
    // visible the cycle after the stop sample; a same-cycle pop makes room.
    assign rx_stop_now = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
    assign fifo_pop    = readRX & ~fifo_empty;
    assign fifo_push   = rx_stop_now & rxs & (~fifo_full | fifo_pop);

    // Receiver: half-bit delay to the middle of the start bit, then one sample
    // per bit period. Returning to idle on the stop sample lets a following
    // start bit be caught without losing half a bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rxOverrun  <= 1'b0;
            rxFrameErr <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rxs) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (!rxs) begin
                            rxFrameErr <= 1'b1;
                        end else if (fifo_full && !fifo_pop) begin
                            rxOverrun <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH     (RX_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (rx_shift),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign charReady = ~fifo_empty;
    assign RXchar    = fifo_head;

    // Transmitter: TxD and TXempty are both registered so the line never
    // glitches. Each level is held exactly DIV cycles; TXempty rises as the
    // stop bit completes so a new write can follow with no idle gap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            TxD      <= 1'b1;
            TXempty  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    TxD <= 1'b1;
                    if (writeTX) begin
                        tx_shift <= TXchar;
                        tx_cnt   <= '0;
                        TxD      <= 1'b0;
                        TXempty  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        TxD      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            TxD      <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            TxD      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        TXempty  <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule
